uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Configurable UART transmitter with a small input FIFO and a valid/ready write port.
//  Serialises 5..8 data bits LSB-first, with optional even/odd parity and 1 or 2 stop bits,
//  at five selectable baud rates.
//  Sits between a byte producer (CPU/bus bridge, test pattern gen) and the TX pin.
//  Sends back-to-back frames with no idle gap while the FIFO holds data.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency; baud divisors derived from it
//  FIFO_DEPTH  4           input FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  s_valid     in   1   producer has a byte on s_data
//  s_ready     out  1   FIFO can accept; write occurs when s_valid && s_ready
//  s_data      in   8   byte to send; unused MSBs ignored when data_bits < 8
//  data_bits   in   2   00=5, 01=6, 10=7, 11=8 data bits
//  parity      in   2   00=none, 01=even, 10=odd, 11=none
//  stop2       in   1   0=1 stop bit, 1=2 stop bits
//  bps         in   3   000=9600 001=19200 010=38400 011=57600 100=115200 101..111=9600
//  q           out  1   serial TX line, idle high
//  busy        out  1   frame in progress or FIFO non-empty
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): q=1, s_ready=1, busy=0, fifo_level=0,
//   FIFO flushed, FSM->IDLE, counters 0. Partial frame is abandoned, never resumed.
//  Divisor DIV = round(CLK_HZ/baud); at 50 MHz: 5208, 2604, 1302, 868, 434.
//   Every bit (start/data/parity/stop) holds q for exactly DIV clocks.
//  FIFO: s_ready = !full. Push on s_valid&&s_ready. Pop only at frame start.
//   Push and pop in the same cycle are both honoured; level unchanged.
//   No bypass: a byte pushed at edge t is visible at the FIFO head after edge t.
//  FSM IDLE->START->DATA->[PARITY]->STOP->(START | IDLE):
//   IDLE: if FIFO non-empty: pop head; latch data, data_bits, parity, stop2, DIV; q<=0; ->START.
//     Latency: push into empty idle block at edge t -> q falls at edge t+1.
//   START: after DIV clocks q<=data[0]; ->DATA, bit index 0.
//   DATA: every DIV clocks shift next bit out; after bit N-1 (N = latched width):
//     ->PARITY if parity in {01,10}, else ->STOP with q<=1.
//   PARITY: q = XOR of the N data bits (even), inverted (odd); after DIV clocks q<=1, ->STOP.
//   STOP: holds q=1 for DIV clocks (2*DIV if stop2).
//     At the end: if FIFO non-empty, pop and q<=0 on the same edge (->START); else ->IDLE.
//  Config inputs are sampled only at frame start; changes mid-frame affect the next frame only.
//  Frame length in bits = 1 + N + (parity?1:0) + (stop2?2:1); 8N1 = 10 bits, 7E2 = 11 bits.
//  busy = (state != IDLE) || (fifo_level != 0). busy rises at the edge a byte is pushed.
//   It falls at the edge ending the last stop bit when the FIFO is empty.
//  Bit counter: $clog2(max DIV) bits, counts 0..DIV-1 and wraps.
//   Bit-index counter: 3 bits. No overflow is possible.
// STRUCTURE
//  Package uart_pkg:
//   - parity enum (PAR_NONE, PAR_EVEN, PAR_ODD)
//   - bps code constants
//   - function baud_div(clk_hz, code) returning the rounded DIV
//   - data_bits decode
//  Sub-module uart_fifo: sync FIFO, width 8, depth FIFO_DEPTH, with full/empty/level outputs.
//  Top: FSM, baud counter, shift register, parity accumulator.
// TESTING (CLK_HZ=50 MHz)
//  1. Reset, bps=100, 8N1, push 0xA5 -> q low at the next edge, 434 clk/bit.
//     Bits 1,0,1,0,0,1,0,1 then stop; 4340 clk total; busy falls after.
//  2. 7E2 at bps=000, push 0x35 -> 7 data bits 1,0,1,0,1,1,0; parity 0; two stop bits;
//     11*5208 clk.
//  3. 5O1, push 0xFF -> data 11111, parity bit 0; s_data[7:5] ignored.
//  4. Push 6 bytes back-to-back, DEPTH=4 -> s_ready low when level=4.
//     Frames contiguous with no idle gap; bytes sent in order; level returns to 0.
//  5. Change bps and parity mid-frame -> current frame unchanged; next frame uses new config.
//  6. Assert rst_n during the DATA state -> q=1 immediately (async); level=0; busy=0.
//     A later push starts a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, baud-rate codes and config decode helpers for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  localparam logic [2:0] BPS_9600   = 3'd0;
  localparam logic [2:0] BPS_19200  = 3'd1;
  localparam logic [2:0] BPS_38400  = 3'd2;
  localparam logic [2:0] BPS_57600  = 3'd3;
  localparam logic [2:0] BPS_115200 = 3'd4;
  function automatic int baud_div(input int clk_hz, input logic [2:0] code);
    int baud;
    baud = code == BPS_19200 ? 19200 : code == BPS_38400 ? 38400 :
           code == BPS_57600 ? 57600 : code == BPS_115200 ? 115200 : 9600;
    return (clk_hz + baud / 2) / baud;
  endfunction
  function automatic logic [2:0] last_bit(input logic [1:0] data_bits);
    return 3'd4 + {1'b0, data_bits};
  endfunction
  function automatic parity_t par_decode(input logic [1:0] parity);
    return parity == 2'b01 ? PAR_EVEN : parity == 2'b10 ? PAR_ODD : PAR_NONE;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: byte-wide synchronous FIFO
//   clk, rst_n (async, active low); i_push/i_data write; i_pop advances head;
//   o_data head entry, o_full, o_empty, o_level entries stored
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  assign o_data  = r_mem[r_rd];
  assign o_full  = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with input FIFO and valid/ready write port
//   clk, rst_n (async, active low); s_valid/s_ready/s_data byte write port;
//   data_bits, parity, stop2, bps frame config, sampled at frame start;
//   q serial line (idle high); busy frame active or FIFO non-empty; fifo_level entries stored
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [7:0]                    s_data,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity,
  input  logic                          stop2,
  input  logic [2:0]                    bps,
  output logic                          q,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(baud_div(CLK_HZ, BPS_9600));
  // bit-time limits are stored as DIV-1 so the counter width covers them exactly
  localparam logic [CW-1:0] L0 = CW'(baud_div(CLK_HZ, BPS_9600) - 1);
  localparam logic [CW-1:0] L1 = CW'(baud_div(CLK_HZ, BPS_19200) - 1);
  localparam logic [CW-1:0] L2 = CW'(baud_div(CLK_HZ, BPS_38400) - 1);
  localparam logic [CW-1:0] L3 = CW'(baud_div(CLK_HZ, BPS_57600) - 1);
  localparam logic [CW-1:0] L4 = CW'(baud_div(CLK_HZ, BPS_115200) - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;
  logic [7:0]    w_head, w_mask;
  logic          w_empty, w_full, w_pop, w_tick, w_end;
  logic [2:0]    w_last;
  logic [CW-1:0] w_lim;
  parity_t       w_par;
  logic [2:0]    r_state, r_idx, r_last;
  logic [CW-1:0] r_cnt, r_lim;
  logic [7:0]    r_shift;
  logic          r_par_en, r_par_bit, r_stop2, r_stop_hi, r_q;
  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (s_valid && s_ready),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );
  assign s_ready = !w_full;
  assign q       = r_q;
  assign busy    = r_state != S_IDLE || fifo_level != '0;
  assign w_tick  = r_cnt == r_lim;
  // r_stop_hi marks the second stop-bit period so the counter never needs 2*DIV range
  assign w_end   = r_state == S_STOP && w_tick && (!r_stop2 || r_stop_hi);
  assign w_pop   = !w_empty && (r_state == S_IDLE || w_end);
  assign w_last  = last_bit(data_bits);
  assign w_mask  = 8'hFF >> (3'd7 - w_last);
  assign w_par   = par_decode(parity);
  assign w_lim   = bps == BPS_19200 ? L1 : bps == BPS_38400 ? L2 :
                   bps == BPS_57600 ? L3 : bps == BPS_115200 ? L4 : L0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_lim     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_stop_hi <= 1'b0;
      r_q       <= 1'b1;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + CW'(1);
      if (w_pop) begin
        r_state   <= S_START;
        r_q       <= 1'b0;
        r_shift   <= w_head & w_mask;
        r_last    <= w_last;
        r_lim     <= w_lim;
        r_par_en  <= w_par != PAR_NONE;
        r_par_bit <= ^(w_head & w_mask) ^ (w_par == PAR_ODD);
        r_stop2   <= stop2;
        r_stop_hi <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          S_START: begin
            r_q     <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_idx == r_last) begin
              r_q       <= r_par_en ? r_par_bit : 1'b1;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
              r_stop_hi <= 1'b0;
            end else begin
              r_q     <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 3'd1;
            end
          end
          S_PARITY: begin
            r_q       <= 1'b1;
            r_state   <= S_STOP;
            r_stop_hi <= 1'b0;
          end
          S_STOP: begin
            if (w_end) r_state <= S_IDLE;
            else r_stop_hi <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg at 50 MHz
module tb_uart_tx_cfg;
  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          div;
    bit          contig;
  } frame_t;
  logic       clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, stop2 = 1'b0;
  logic       s_ready, q, busy;
  logic [7:0] s_data = '0;
  logic [1:0] data_bits = 2'b11, parity = 2'b00;
  logic [2:0] bps = 3'b100;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0, cyc = 0, frames_done = 0;
  int start_cyc = 0, last_end = 0, push_cyc = 0;
  bit mon_en = 1'b1;
  frame_t sb[$];
  uart_tx_cfg #(.CLK_HZ(50_000_000), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .data_bits  (data_bits),
    .parity     (parity),
    .stop2      (stop2),
    .bps        (bps),
    .q          (q),
    .busy       (busy),
    .fifo_level (fifo_level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic frame_t mk(input logic [7:0] d, input bit contig);
    frame_t f;
    int n, k;
    logic p;
    n = 5 + int'(data_bits);
    f.bits = '1;
    f.bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = d[i];
      p ^= d[i];
    end
    k = 1 + n;
    if (parity == 2'b01 || parity == 2'b10) begin
      f.bits[k] = p ^ (parity == 2'b10);
      k++;
    end
    f.nb = k + (stop2 ? 2 : 1);
    f.div = bps == 3'd1 ? 2604 : bps == 3'd2 ? 1302 : bps == 3'd3 ? 868 : bps == 3'd4 ? 434 : 5208;
    f.contig = contig;
    return f;
  endfunction
  task automatic push(input logic [7:0] d, input bit contig);
    int n = 0;
    sb.push_back(mk(d, contig));
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && n < 70000) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait", 32'(n < 70000), 1);
    @(negedge clk);
    s_valid = 1'b0;
    push_cyc = cyc;
  endtask
  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_done", frames_done, target);
    repeat (4) @(negedge clk);
  endtask
  initial begin : monitor
    frame_t f;
    int bad;
    forever begin
      @(negedge clk);
      if (mon_en && sb.size() != 0 && q === 1'b0) begin
        f = sb.pop_front();
        if (f.contig) chk("gap", cyc, last_end);
        start_cyc = cyc;
        for (int b = 0; b < f.nb; b++) begin
          bad = 0;
          for (int k = 0; k < f.div; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (q !== f.bits[b]) bad++;
          end
          chk($sformatf("bit%0d", b), bad, 0);
        end
        chk("busy_in", busy, 1);
        last_end = cyc + 1;
        frames_done++;
        if (sb.size() == 0) begin
          @(negedge clk);
          chk("busy_fall", busy, 0);
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_q", q, 1);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'hA5, 1'b0);
    chk("t1_q_hold", q, 1);
    chk("t1_busy", busy, 1);
    chk("t1_level", fifo_level, 1);
    @(negedge clk);
    chk("t1_q_start", q, 0);
    chk("t1_level_pop", fifo_level, 0);
    wait_done(1, 5000);
    chk("t1_latency", start_cyc, push_cyc + 1);
    data_bits = 2'b00;
    parity = 2'b10;
    push(8'hFF, 1'b0);
    wait_done(2, 4000);
    data_bits = 2'b10;
    parity = 2'b01;
    stop2 = 1'b1;
    bps = 3'b000;
    push(8'h35, 1'b0);
    repeat (100) @(negedge clk);
    chk("t2_busy", busy, 1);
    data_bits = 2'b00;
    parity = 2'b00;
    stop2 = 1'b0;
    bps = 3'b100;
    push(8'h11, 1'b1);
    push(8'h02, 1'b1);
    push(8'h13, 1'b1);
    push(8'h04, 1'b1);
    chk("t4_level_full", fifo_level, 4);
    chk("t4_ready_low", s_ready, 0);
    push(8'h1F, 1'b1);
    push(8'h0A, 1'b1);
    wait_done(9, 30000);
    chk("t4_level_end", fifo_level, 0);
    data_bits = 2'b11;
    mon_en = 1'b0;
    push(8'h5A, 1'b0);
    sb.delete();
    repeat (700) @(negedge clk);
    chk("t6_pre_q", q, 0);
    chk("t6_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_q", q, 1);
    chk("t6_level", fifo_level, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("t6_idle_q", q, 1);
    push(8'h3C, 1'b0);
    wait_done(10, 5000);
    chk("t6_latency", start_cyc, push_cyc + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
